// File: rtl/jk_pkg.sv
// Shared constants for the JK register bank: operation select codes and
// the two-bit {j,k} codes understood by each jk_cell.
package jk_pkg;

    localparam logic [2:0] MODE_JK    = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_UP    = 3'b010;
    localparam logic [2:0] MODE_DOWN  = 3'b011;
    localparam logic [2:0] MODE_SHL   = 3'b100;
    localparam logic [2:0] MODE_SHR   = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_HOLD  = 3'b111;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Forcing a cell to a known target value is always expressed as set or clear.
    function automatic logic [1:0] set_clr(input logic target);
        return target ? JK_SET : JK_CLR;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One-bit JK flip-flop with a synchronous reset to a per-bit value and an
// enable that freezes the bit when low.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            case ({j, k})
                JK_HOLD: q_d = q_q;
                JK_CLR:  q_d = 1'b0;
                JK_SET:  q_d = 1'b1;
                JK_TGL:  q_d = ~q_q;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// Multi-mode register bank built from WIDTH independent JK cells; every
// operation is translated into per-bit {j,k} codes, plus a registered wrap pulse.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             wrap,
    output logic             zero
);

    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic             lower_ones;
    logic             lower_zeros;
    logic [1:0]       code;
    logic             wrap_d;
    logic             wrap_q;

    assign shl_val = {q[WIDTH-2:0], ser_in};
    assign shr_val = {ser_in, q[WIDTH-1:1]};

    // lower_ones/lower_zeros track whether all bits below i are 1/0, giving the
    // toggle-enable for each stage of the up/down counter chains.
    always_comb begin
        cell_j      = '0;
        cell_k      = '0;
        lower_ones  = 1'b1;
        lower_zeros = 1'b1;
        code        = JK_HOLD;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_JK:    code = {j[i], k[i]};
                MODE_LOAD:  code = set_clr(d[i]);
                MODE_UP:    code = lower_ones  ? JK_TGL : JK_HOLD;
                MODE_DOWN:  code = lower_zeros ? JK_TGL : JK_HOLD;
                MODE_SHL:   code = set_clr(shl_val[i]);
                MODE_SHR:   code = set_clr(shr_val[i]);
                MODE_CLEAR: code = JK_CLR;
                MODE_HOLD:  code = JK_HOLD;
                default:    code = JK_HOLD;
            endcase
            cell_j[i]   = code[1];
            cell_k[i]   = code[0];
            lower_ones  = lower_ones & q[i];
            lower_zeros = lower_zeros & ~q[i];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[g]),
            .en      (en),
            .j       (cell_j[g]),
            .k       (cell_k[g]),
            .q       (q[g])
        );
    end

    always_comb begin
        wrap_d = en && (((mode == MODE_UP)   && (&q)) ||
                        ((mode == MODE_DOWN) && ~(|q)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap  = wrap_q;
    assign q_bar = ~q;
    assign zero  = (q == '0);

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: an 8-bit instance with RST_VAL=A5 and a
// 4-bit instance; expected results go through a scoreboard queue.
module tb_jk_reg_bank;
    import jk_pkg::*;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] d;
        logic       ser;
        logic [7:0] exp_q;
        logic       exp_wrap;
    } step_t;

    typedef struct {
        logic [7:0] q;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = MODE_HOLD;
    logic [7:0] j = '0;
    logic [7:0] k = '0;
    logic [7:0] d = '0;
    logic       ser_in = 1'b0;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic       wrap;
    logic       zero;

    logic       rst4 = 1'b1;
    logic       en4 = 1'b0;
    logic [2:0] mode4 = MODE_HOLD;
    logic [3:0] j4 = '0;
    logic [3:0] k4 = '0;
    logic [3:0] d4 = '0;
    logic       ser4 = 1'b0;
    logic [3:0] q4;
    logic [3:0] q_bar4;
    logic       wrap4;
    logic       zero4;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] model_q;

    always #5 clk = ~clk;

    jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .ser_in(ser_in), .q(q), .q_bar(q_bar), .wrap(wrap), .zero(zero)
    );

    jk_reg_bank #(.WIDTH(4), .RST_VAL(4'h0)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .j(j4), .k(k4), .d(d4),
        .ser_in(ser4), .q(q4), .q_bar(q_bar4), .wrap(wrap4), .zero(zero4)
    );

    function automatic step_t mk(input logic r, input logic e, input logic [2:0] m,
                                 input logic [7:0] jj, input logic [7:0] kk,
                                 input logic [7:0] dd, input logic s,
                                 input logic [7:0] eq, input logic ew);
        step_t st;
        st.rst = r; st.en = e; st.mode = m; st.j = jj; st.k = kk; st.d = dd;
        st.ser = s; st.exp_q = eq; st.exp_wrap = ew;
        return st;
    endfunction

    // Reference behaviour written arithmetically, independent of the JK mapping.
    function automatic exp_t model(input step_t st, input logic [7:0] cur);
        exp_t r;
        r.q = cur;
        r.wrap = 1'b0;
        if (st.rst) begin
            r.q = 8'hA5;
        end else if (st.en) begin
            case (st.mode)
                MODE_JK:    r.q = (cur & ~st.j & ~st.k) | (st.j & ~st.k) | (~cur & st.j & st.k);
                MODE_LOAD:  r.q = st.d;
                MODE_UP:    r.q = cur + 8'd1;
                MODE_DOWN:  r.q = cur - 8'd1;
                MODE_SHL:   r.q = {cur[6:0], st.ser};
                MODE_SHR:   r.q = {st.ser, cur[7:1]};
                MODE_CLEAR: r.q = 8'h00;
                default:    r.q = cur;
            endcase
            r.wrap = ((st.mode == MODE_UP) && (cur == 8'hFF)) ||
                     ((st.mode == MODE_DOWN) && (cur == 8'h00));
        end
        return r;
    endfunction

    task automatic drive_step(input step_t st);
        exp_t e;
        @(negedge clk);
        rst = st.rst; en = st.en; mode = st.mode; j = st.j; k = st.k;
        d = st.d; ser_in = st.ser;
        e.q = st.exp_q;
        e.wrap = st.exp_wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive_step(mk(1, 1, MODE_UP, 8'h00, 8'h00, 8'h00, 0, 8'hA5, 0));
        e = sb.pop_front();
        checks++;
        if (q !== e.q || q_bar !== 8'h5A || wrap !== e.wrap || zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: q=%h q_bar=%h wrap=%b zero=%b, want q=%h q_bar=5a wrap=%b zero=0",
                     q, q_bar, wrap, zero, e.q, e.wrap);
        end
    endtask

    task automatic run_table(input string name, input step_t steps[$]);
        exp_t e;
        for (int i = 0; i < steps.size(); i++) begin
            drive_step(steps[i]);
            e = sb.pop_front();
            checks++;
            if (q !== e.q || wrap !== e.wrap || zero !== (e.q == 8'h00) || q_bar !== ~e.q) begin
                errors++;
                $display("[TB] FAIL %s step %0d: q=%h wrap=%b zero=%b q_bar=%h, want q=%h wrap=%b zero=%b q_bar=%h",
                         name, i, q, wrap, zero, q_bar, e.q, e.wrap, (e.q == 8'h00), ~e.q);
            end
        end
    endtask

    task automatic test_jk();
        step_t s[$];
        s.push_back(mk(0, 1, MODE_LOAD, 8'h00, 8'h00, 8'h0F, 0, 8'h0F, 0));
        s.push_back(mk(0, 1, MODE_JK,   8'hF0, 8'h3C, 8'h00, 0, 8'hF3, 0));
        s.push_back(mk(0, 1, MODE_JK,   8'h00, 8'h00, 8'hFF, 1, 8'hF3, 0));
        run_table("jk", s);
    endtask

    task automatic test_count();
        step_t s[$];
        s.push_back(mk(0, 1, MODE_LOAD, 0, 0, 8'hFE, 0, 8'hFE, 0));
        s.push_back(mk(0, 1, MODE_UP,   0, 0, 8'h00, 0, 8'hFF, 0));
        s.push_back(mk(0, 1, MODE_UP,   0, 0, 8'h00, 0, 8'h00, 1));
        s.push_back(mk(0, 1, MODE_UP,   0, 0, 8'h00, 0, 8'h01, 0));
        s.push_back(mk(0, 1, MODE_LOAD, 0, 0, 8'h01, 0, 8'h01, 0));
        s.push_back(mk(0, 1, MODE_DOWN, 0, 0, 8'h00, 0, 8'h00, 0));
        s.push_back(mk(0, 1, MODE_DOWN, 0, 0, 8'h00, 0, 8'hFF, 1));
        s.push_back(mk(0, 1, MODE_DOWN, 0, 0, 8'h00, 0, 8'hFE, 0));
        run_table("count", s);
    endtask

    task automatic test_shift_enable();
        step_t s[$];
        s.push_back(mk(0, 1, MODE_LOAD,  0, 0, 8'h81, 0, 8'h81, 0));
        s.push_back(mk(0, 1, MODE_SHL,   0, 0, 8'h00, 1, 8'h03, 0));
        s.push_back(mk(0, 0, MODE_LOAD,  0, 0, 8'h55, 1, 8'h03, 0));
        s.push_back(mk(0, 1, MODE_SHR,   0, 0, 8'h00, 0, 8'h01, 0));
        s.push_back(mk(0, 1, MODE_LOAD,  0, 0, 8'hFF, 0, 8'hFF, 0));
        s.push_back(mk(0, 0, MODE_UP,    0, 0, 8'h00, 0, 8'hFF, 0));
        s.push_back(mk(0, 1, MODE_CLEAR, 0, 0, 8'hFF, 1, 8'h00, 0));
        s.push_back(mk(0, 0, MODE_DOWN,  0, 0, 8'h00, 0, 8'h00, 0));
        s.push_back(mk(0, 1, MODE_HOLD,  8'hFF, 8'h00, 8'hFF, 1, 8'h00, 0));
        run_table("shift_enable", s);
    endtask

    task automatic test_reset_abort();
        step_t s[$];
        s.push_back(mk(0, 1, MODE_LOAD, 0, 0, 8'hFF, 0, 8'hFF, 0));
        s.push_back(mk(1, 1, MODE_UP,   0, 0, 8'h00, 0, 8'hA5, 0));
        s.push_back(mk(0, 1, MODE_UP,   0, 0, 8'h00, 0, 8'hA6, 0));
        run_table("reset_abort", s);
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        step_t st;
        exp_t  r;
        logic [7:0] picks [4];
        picks[0] = 8'hFF; picks[1] = 8'h00; picks[2] = 8'h01; picks[3] = 8'hFE;
        model_q = 8'hXX;
        for (int i = 0; i < 80; i++) begin
            st = mk(i == 0 || ($urandom % 20 == 0), ($urandom % 5) != 0,
                    3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    ($urandom % 2) ? picks[$urandom % 4] : 8'($urandom),
                    1'($urandom), 8'h00, 0);
            r = model(st, model_q);
            st.exp_q = r.q;
            st.exp_wrap = r.wrap;
            model_q = r.q;
            s.push_back(st);
        end
        run_table("back_to_back", s);
    endtask

    task automatic test_width4();
        logic [2:0] m  [5];
        logic [3:0] eq [5];
        logic       ew [5];
        logic       er [5];
        exp_t e;
        m[0] = MODE_UP;   eq[0] = 4'h0; ew[0] = 0; er[0] = 1;
        m[1] = MODE_LOAD; eq[1] = 4'hE; ew[1] = 0; er[1] = 0;
        m[2] = MODE_UP;   eq[2] = 4'hF; ew[2] = 0; er[2] = 0;
        m[3] = MODE_UP;   eq[3] = 4'h0; ew[3] = 1; er[3] = 0;
        m[4] = MODE_UP;   eq[4] = 4'h1; ew[4] = 0; er[4] = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst4 = er[i]; en4 = 1'b1; mode4 = m[i]; d4 = 4'hE; ser4 = 1'b0;
            e.q = {4'h0, eq[i]};
            e.wrap = ew[i];
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (q4 !== e.q[3:0] || wrap4 !== e.wrap || zero4 !== (e.q[3:0] == 4'h0) || q_bar4 !== ~e.q[3:0]) begin
                errors++;
                $display("[TB] FAIL width4 step %0d: q=%h wrap=%b zero=%b q_bar=%h, want q=%h wrap=%b zero=%b",
                         i, q4, wrap4, zero4, q_bar4, e.q[3:0], e.wrap, (e.q[3:0] == 4'h0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_jk();
        test_count();
        test_shift_enable();
        test_reset_abort();
        test_back_to_back();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the register width in bits (minimum 2).
REQ-002 SHALL have parameter RST_VAL, default 0, meaning the WIDTH-bit value of q after reset.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, meaning the operation enable; when low, q holds.
REQ-006 SHALL have port mode, input, 3 bits, meaning the operation select (see REQ-014).
REQ-007 SHALL have ports j and k, input, WIDTH bits each, meaning per-bit JK controls used in JK mode.
REQ-008 SHALL have port d, input, WIDTH bits, meaning the parallel load data.
REQ-009 SHALL have port ser_in, input, 1 bit, meaning the serial input bit for shift modes.
REQ-010 SHALL have port q, output, WIDTH bits, meaning the registered state.
REQ-011 SHALL have port q_bar, output, WIDTH bits, meaning the combinational bitwise complement of q.
REQ-012 SHALL have port wrap, output, 1 bit, meaning a registered one-cycle pulse on count wrap-around.
REQ-013 SHALL have port zero, output, 1 bit, meaning a combinational flag that is high when q equals 0.

Function
REQ-014 mode encoding SHALL be: 000 JK, 001 LOAD, 010 UP, 011 DOWN, 100 SHL, 101 SHR, 110 CLEAR, 111 HOLD.
REQ-015 JK mode SHALL apply, per bit i, {j[i],k[i]}: 00 hold, 01 clear, 10 set, 11 toggle, all bits independent.
REQ-016 LOAD SHALL set q to d on the next edge.
REQ-017 UP SHALL be a toggle chain: bit 0 always toggles; bit i toggles iff q[i-1:0] is all ones; result q+1 modulo 2^WIDTH.
REQ-018 DOWN SHALL be a toggle chain: bit 0 always toggles; bit i toggles iff q[i-1:0] is all zeros; result q-1 modulo 2^WIDTH.
REQ-019 SHL SHALL set q to {q[WIDTH-2:0], ser_in}.
REQ-020 SHR SHALL set q to {ser_in, q[WIDTH-1:1]}.
REQ-021 CLEAR SHALL set q to 0 (not RST_VAL).
REQ-022 HOLD SHALL keep q unchanged.
REQ-023 Latency: q SHALL reflect the operation one clock after the sampling edge; j, k, d, ser_in and mode SHALL be sampled only when en is high.
REQ-024 wrap SHALL be high for exactly the one cycle following an edge where en=1 and either mode=UP with q all ones, or mode=DOWN with q all zeros; otherwise it SHALL be 0.
REQ-025 With en=0, q SHALL hold and wrap SHALL be 0 regardless of mode.
REQ-026 Mode changes between consecutive cycles SHALL take effect immediately, with no intermediate state.

Reset
REQ-027 rst high at an edge SHALL set q=RST_VAL and wrap=0, overriding en and mode.
REQ-028 Reset during a count SHALL abort the count; no wrap pulse SHALL be produced for that edge.
REQ-029 After rst deasserts, the first enabled edge SHALL operate on q=RST_VAL.

Structure
REQ-030 A shared package jk_pkg SHALL hold the mode localparams (MODE_JK..MODE_HOLD) and the JK code constants (JK_HOLD, JK_CLR, JK_SET, JK_TGL).
REQ-031 A one-bit sub-module jk_cell (clk, rst, rst_val, en, j, k, q) SHALL be instantiated WIDTH times.
REQ-032 The top level SHALL map every mode onto per-cell j/k values: LOAD maps d[i] to set/clear; UP/DOWN map the toggle-enable to 11; SHL/SHR/CLEAR map the target bit to set/clear.
REQ-033 wrap SHALL be a separate top-level register.

Verification
REQ-034 rst=1 with RST_VAL=8'hA5 -> q=A5, q_bar=5A, wrap=0, zero=0.
REQ-035 JK mode with q=0F, j=F0, k=3C -> q=F3 (bits 7:6 set, 5:4 toggled to 1, 3:2 cleared, 1:0 held).
REQ-036 LOAD d=FE, then UP for 3 cycles -> q=FF, 00, 01; wrap=1 only in the cycle q=00; zero=1 in that cycle.
REQ-037 LOAD 01, then DOWN for 2 cycles -> q=00, FF; wrap=1 only in the cycle q=FF.
REQ-038 LOAD 81, SHL with ser_in=1 -> q=03; SHR with ser_in=0 -> q=01; toggling en=0 mid-sequence -> q holds and wrap=0.
REQ-039 UP from FF with rst=1 at the wrap edge -> q=RST_VAL, wrap=0; WIDTH=4 build repeats REQ-036 with values E, F, 0, 1.
